// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the pipeline (IF/MEM requesters), the unified-memory
// arbiter and the external single-ported memory.
// slave  : the arbiter side.
// master : the environment side (pipeline stages plus external memory).
interface pipe_mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stall_o;
  logic        ext_req_o;
  logic        ext_we_o;
  logic [31:0] ext_addr_o;
  logic [31:0] ext_wdata_o;
  logic [31:0] ext_rdata_i;
  logic        ext_ack_i;
  logic        err_o;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
           ext_rdata_i, ext_ack_i,
    output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_o,
           ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
           ext_rdata_i, ext_ack_i,
    input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_o,
           ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o, err_o
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. Data wins by default; after STARVE_MAX consecutive data grants
// with a fetch waiting, fetch is forced through.
// Optional macro MEM_ARB_TIMEOUT_EN: aborts an access after TIMEOUT_CYC busy
// cycles without ext_ack_i, returns 32'hDEADBEEF and sets sticky err_o.
//
// state  | meaning
// IDLE   | no access outstanding, arbitrating this cycle
// BUSY_I | fetch holding the external memory handshake
// BUSY_D | load/store holding the external memory handshake
module pipe_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic        grant_d;
  logic        grant_i;
  logic        busy;
  logic        tmo_hit;
  logic        done;
  logic [31:0] done_rdata;

  // Arbitration: data first unless the fetch side has been starved too long.
  always_comb begin
    busy    = (state != IDLE);
    grant_d = (state == IDLE) && bus.mem_req_i &&
              (!bus.if_req_i || (starve_cnt < STARVE_LIM));
    grant_i = (state == IDLE) && bus.if_req_i && !grant_d;
    // An ext_ack_i on the timeout edge takes precedence over the abort.
    done       = busy && (bus.ext_ack_i || tmo_hit);
    done_rdata = bus.ext_ack_i ? bus.ext_rdata_i : 32'hDEADBEEF;
  end

  assign bus.stall_o = (bus.if_req_i  && !bus.if_ack_o) ||
                       (bus.mem_req_i && !bus.mem_ack_o);

  // Main FSM: grant, hold the external handshake, complete with an ack pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      bus.ext_req_o   <= 1'b0;
      bus.ext_we_o    <= 1'b0;
      bus.ext_addr_o  <= '0;
      bus.ext_wdata_o <= '0;
      bus.if_ack_o    <= 1'b0;
      bus.mem_ack_o   <= 1'b0;
      bus.if_rdata_o  <= '0;
      bus.mem_rdata_o <= '0;
    end else begin
      bus.if_ack_o  <= 1'b0;
      bus.mem_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state           <= BUSY_D;
            bus.ext_req_o   <= 1'b1;
            bus.ext_we_o    <= bus.mem_we_i;
            bus.ext_addr_o  <= bus.mem_addr_i;
            bus.ext_wdata_o <= bus.mem_wdata_i;
          end else if (grant_i) begin
            state          <= BUSY_I;
            bus.ext_req_o  <= 1'b1;
            bus.ext_we_o   <= 1'b0;
            bus.ext_addr_o <= bus.if_addr_i;
          end
        end
        BUSY_I: begin
          if (done) begin
            state          <= IDLE;
            bus.ext_req_o  <= 1'b0;
            bus.if_ack_o   <= 1'b1;
            bus.if_rdata_o <= done_rdata;
          end
        end
        BUSY_D: begin
          if (done) begin
            state         <= IDLE;
            bus.ext_req_o <= 1'b0;
            bus.mem_ack_o <= 1'b1;
            if (!bus.ext_we_o) bus.mem_rdata_o <= done_rdata;
          end
        end
        default: begin
          state         <= IDLE;
          bus.ext_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: data grants taken over a waiting fetch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_i || !bus.if_req_i) starve_cnt <= '0;
      else if (grant_d && (starve_cnt != 4'd15)) starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = busy && (tmo_cnt == '0) && !bus.ext_ack_i;

  // Busy timer: loaded at grant, terminal count on the last allowed busy cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      bus.err_o <= 1'b0;
    end else begin
      if (grant_d || grant_i) tmo_cnt <= TMO_LOAD;
      else if (busy && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - 1'b1;
      if (tmo_hit) bus.err_o <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter with a small external memory responder.
module tb_pipe_mem_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;

  pipe_mem_arbiter_if bus();

  pipe_mem_arbiter #(
    .STARVE_MAX(4)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat = 1;
  bit no_ack = 1'b0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] gq [$];
  int gt [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // External memory: acks after lat cycles of ext_req_o, logs each grant.
  initial begin
    bit prev;
    int wc;
    prev = 1'b0;
    wc = 0;
    bus.ext_ack_i = 1'b0;
    bus.ext_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      bus.ext_ack_i = 1'b0;
      if (bus.ext_req_o && !prev) begin
        gq.push_back(bus.ext_addr_o);
        gt.push_back(cyc);
      end
      prev = bus.ext_req_o;
      if (bus.ext_req_o) begin
        wc++;
        if (!no_ack && wc >= lat) begin
          bus.ext_ack_i = 1'b1;
          wc = 0;
          if (bus.ext_we_o) mem_model[bus.ext_addr_o] = bus.ext_wdata_o;
          else if (mem_model.exists(bus.ext_addr_o)) bus.ext_rdata_i = mem_model[bus.ext_addr_o];
          else bus.ext_rdata_i = 32'h0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_order [10];
    int pulses;
    exp_order = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000,
                  32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000};

    rst_i = 1'b1;
    bus.if_req_i = 1'b0;
    bus.if_addr_i = '0;
    bus.mem_req_i = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_wdata_i = '0;
    mem_model[32'h10] = 32'h0050_0093;
    repeat (3) tick;

    check("rst_ext_req", {31'd0, bus.ext_req_o}, 32'd0);
    check("rst_ext_we", {31'd0, bus.ext_we_o}, 32'd0);
    check("rst_ext_addr", bus.ext_addr_o, 32'd0);
    check("rst_ext_wdata", bus.ext_wdata_o, 32'd0);
    check("rst_if_ack", {31'd0, bus.if_ack_o}, 32'd0);
    check("rst_mem_ack", {31'd0, bus.mem_ack_o}, 32'd0);
    check("rst_if_rdata", bus.if_rdata_o, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    rst_i = 1'b0;
    tick;

    // Single fetch, memory acks in the first busy cycle.
    lat = 1;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h10;
    #1;
    check("f_stall_req", {31'd0, bus.stall_o}, 32'd1);
    tick;
    check("f_ext_req", {31'd0, bus.ext_req_o}, 32'd1);
    check("f_ext_addr", bus.ext_addr_o, 32'h10);
    check("f_ext_we", {31'd0, bus.ext_we_o}, 32'd0);
    check("f_ack_early", {31'd0, bus.if_ack_o}, 32'd0);
    check("f_stall_busy", {31'd0, bus.stall_o}, 32'd1);
    tick;
    check("f_ack", {31'd0, bus.if_ack_o}, 32'd1);
    check("f_rdata", bus.if_rdata_o, 32'h0050_0093);
    check("f_stall_ack", {31'd0, bus.stall_o}, 32'd0);
    check("f_ext_req_drop", {31'd0, bus.ext_req_o}, 32'd0);
    bus.if_req_i = 1'b0;
    tick;
    check("f_ack_pulse", {31'd0, bus.if_ack_o}, 32'd0);
    check("f_rdata_hold", bus.if_rdata_o, 32'h0050_0093);

    // Store with 3-cycle memory latency, then load back.
    lat = 3;
    pulses = 0;
    bus.mem_req_i = 1'b1;
    bus.mem_we_i = 1'b1;
    bus.mem_addr_i = 32'h100;
    bus.mem_wdata_i = 32'hCAFE_F00D;
    for (int i = 1; i <= 3; i++) begin
      tick;
      if (i == 1) bus.mem_wdata_i = 32'h1234_5678;
      pulses += int'(bus.mem_ack_o);
      check("st_ext_req", {31'd0, bus.ext_req_o}, 32'd1);
      check("st_ext_we", {31'd0, bus.ext_we_o}, 32'd1);
      check("st_ext_wdata", bus.ext_wdata_o, 32'hCAFE_F00D);
    end
    tick;
    pulses += int'(bus.mem_ack_o);
    check("st_ack", {31'd0, bus.mem_ack_o}, 32'd1);
    check("st_ext_req_drop", {31'd0, bus.ext_req_o}, 32'd0);
    check("st_rdata_unchanged", bus.mem_rdata_o, 32'd0);
    bus.mem_req_i = 1'b0;
    tick;
    pulses += int'(bus.mem_ack_o);
    check("st_ack_count", pulses, 32'd1);

    lat = 1;
    bus.mem_req_i = 1'b1;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = 32'h100;
    tick;
    check("ld_ext_we", {31'd0, bus.ext_we_o}, 32'd0);
    check("ld_ext_addr", bus.ext_addr_o, 32'h100);
    tick;
    check("ld_ack", {31'd0, bus.mem_ack_o}, 32'd1);
    check("ld_rdata", bus.mem_rdata_o, 32'hCAFE_F00D);
    bus.mem_req_i = 1'b0;
    tick;

    // Contention: both requesters held high.
    gq.delete();
    gt.delete();
    bus.if_addr_i = 32'h1000;
    bus.mem_addr_i = 32'h2000;
    bus.mem_we_i = 1'b0;
    bus.if_req_i = 1'b1;
    bus.mem_req_i = 1'b1;
    for (int i = 0; i < 200 && gq.size() < 10; i++) tick;
    bus.if_req_i = 1'b0;
    bus.mem_req_i = 1'b0;
    check("ct_grant_count", gq.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("ct_grant_%0d", i), (i < gq.size()) ? gq[i] : 32'hFFFF_FFFF, exp_order[i]);
    check("ct_spacing", (gt.size() >= 10) ? 32'(gt[9] - gt[0]) : 32'hFFFF_FFFF, 32'd18);
    tick;
    tick;

    // Input change after grant is ignored.
    lat = 3;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h20;
    tick;
    check("chg_addr_grant", bus.ext_addr_o, 32'h20);
    bus.if_addr_i = 32'h40;
    tick;
    check("chg_addr_b1", bus.ext_addr_o, 32'h20);
    tick;
    check("chg_addr_b2", bus.ext_addr_o, 32'h20);
    tick;
    check("chg_ack", {31'd0, bus.if_ack_o}, 32'd1);
    bus.if_req_i = 1'b0;
    tick;

    // Reset mid-access with the starvation counter already raised.
    gq.delete();
    lat = 1;
    bus.if_addr_i = 32'h1000;
    bus.mem_addr_i = 32'h2000;
    bus.if_req_i = 1'b1;
    bus.mem_req_i = 1'b1;
    for (int i = 0; i < 100 && gq.size() < 3; i++) tick;
    no_ack = 1'b1;
    tick;
    check("rs_grant_d", bus.ext_addr_o, 32'h2000);
    tick;
    tick;
    check("rs_busy", {31'd0, bus.ext_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("rs_ext_req_drop", {31'd0, bus.ext_req_o}, 32'd0);
    tick;
    check("rs_no_ack", {31'd0, bus.mem_ack_o}, 32'd0);
    rst_i = 1'b0;
    no_ack = 1'b0;
    tick;
    check("rs_post_grant", bus.ext_addr_o, 32'h2000);
    check("rs_post_req", {31'd0, bus.ext_req_o}, 32'd1);
    tick;
    check("rs_post_ack", {31'd0, bus.mem_ack_o}, 32'd1);
    bus.if_req_i = 1'b0;
    bus.mem_req_i = 1'b0;
    tick;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers a fetch: abort after 8 busy cycles.
    no_ack = 1'b1;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h30;
    tick;
    repeat (7) tick;
    check("to_still_busy", {31'd0, bus.ext_req_o}, 32'd1);
    check("to_err_early", {31'd0, bus.err_o}, 32'd0);
    tick;
    check("to_ext_req_drop", {31'd0, bus.ext_req_o}, 32'd0);
    check("to_ack", {31'd0, bus.if_ack_o}, 32'd1);
    check("to_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
    check("to_err", {31'd0, bus.err_o}, 32'd1);
    bus.if_req_i = 1'b0;
    no_ack = 1'b0;
    tick;
    check("to_err_sticky", {31'd0, bus.err_o}, 32'd1);
    check("to_ack_pulse", {31'd0, bus.if_ack_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    check("to_err_rst", {31'd0, bus.err_o}, 32'd0);
    tick;
    rst_i = 1'b0;
    tick;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares a single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one requester at a time, holds the granted transaction on the external memory handshake, and returns registered read data with a one-cycle ack pulse.
- Generates the stall signal that freezes PC, IFID and the later pipeline registers while any access is outstanding.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (1..15).
- TIMEOUT_CYC, 64, busy cycles without ext_ack_i before abort (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction, valid with if_ack_o, held until next fetch ack
- if_ack_o  out  1  one-cycle fetch completion pulse
- mem_req_i  in  1  data request; held until mem_ack_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_rdata_o  out  32  load data, valid with mem_ack_o, held until next data ack
- mem_ack_o  out  1  one-cycle data completion pulse
- stall_o  out  1  pipeline stall: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)
- ext_req_o  out  1  external memory request, level, held until ext_ack_i
- ext_we_o  out  1  external write enable
- ext_addr_o  out  32  external address
- ext_wdata_o  out  32  external write data
- ext_rdata_i  in  32  external read data, valid when ext_ack_i = 1
- ext_ack_i  in  1  external completion pulse
- err_o  out  1  sticky timeout error

Behaviour:
- Reset (async): state IDLE. All outputs are 0: ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o, if_ack_o, mem_ack_o, if_rdata_o, mem_rdata_o and err_o. The starvation counter is cleared. A reset mid-transaction drops ext_req_o immediately and abandons the access with no ack.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, at each clock edge:
  - If mem_req_i = 1 and (if_req_i = 0 or starve_cnt < STARVE_MAX): go to BUSY_D.
  - Otherwise, if if_req_i = 1: go to BUSY_I.
  - Otherwise: stay in IDLE.
- Grant actions, taken at the same edge as the transition:
  - Latch address, write enable and write data into the ext_* registers; set ext_req_o = 1.
  - A fetch grant forces ext_we_o = 0.
  - Requester inputs changing after the grant are ignored.
- Starvation counter:
  - Increments (saturating at 15) on each data grant made while if_req_i = 1.
  - Clears on each fetch grant.
  - Clears when if_req_i = 0 in IDLE.
- BUSY_x, on the edge that samples ext_ack_i = 1:
  - ext_req_o = 0 and state returns to IDLE.
  - The matching ack pulses high for exactly one cycle.
  - The matching rdata register captures ext_rdata_i on a load or fetch; a store leaves mem_rdata_o unchanged.
- Latency:
  - Minimum is 2 edges from a request sampled in IDLE to its ack, when ext_ack_i arrives in the first ext_req_o cycle.
  - The next grant occurs no earlier than the edge after the ack edge (one IDLE cycle between transactions).
- A request still high during its own ack cycle is treated as a new request and is re-arbitrated at the next IDLE edge. Requesters must present the next address in that cycle or drop req.
- Simultaneous requests: data wins unless starve_cnt ≥ STARVE_MAX, in which case fetch wins.
- ext_ack_i while in IDLE: ignored.
- Addresses pass through unmodified, including bits [1:0]. There is no alignment checking.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A busy counter runs in BUSY_I and BUSY_D.
  - When it reaches TIMEOUT_CYC without ext_ack_i, ext_req_o drops and the state returns to IDLE.
  - The pending requester's ack pulses with rdata = 32'hDEADBEEF (not written for stores).
  - err_o sets and stays 1 until reset.
  - An ext_ack_i arriving on the timeout edge wins: normal completion, no error.
- Without the macro: the arbiter waits indefinitely; err_o is tied to 0 and no counter logic is present.

Test Plan:
- Single fetch: if_req_i = 1, if_addr_i = 0x0000_0010; memory acks in the first cycle with 0x0050_0093 -> ext_addr_o = 0x10, ext_we_o = 0, if_ack_o pulses at edge 2, if_rdata_o = 0x0050_0093, stall_o = 1 until the ack cycle.
- Store then load: mem_we_i = 1, address 0x100, data 0xCAFEF00D, memory ack latency 3 cycles -> ext_we_o = 1 and ext_wdata_o = 0xCAFEF00D held 3 cycles, mem_ack_o pulses once. A following load of 0x100 returns 0xCAFEF00D on mem_rdata_o.
- Contention: if_req_i and mem_req_i both held high, STARVE_MAX = 4 -> grant order D, D, D, D, I, D, D, D, D, I. An IDLE cycle separates each grant.
- Reset mid-access: assert rst_i two cycles into a BUSY_D with no ext ack -> ext_req_o = 0 immediately, no mem_ack_o, state IDLE, starvation counter 0.
- Requester input change after grant: change if_addr_i from 0x20 to 0x40 the cycle after grant -> ext_addr_o stays 0x20 until ack.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, memory never acks a fetch -> ext_req_o drops after 8 busy cycles, if_ack_o pulses with 0xDEADBEEF, err_o = 1 until rst_i.
